sample_trigger_mc: RTL and testbench
====================================

# sample_trigger_mc

Multi-channel, run-time-configurable successor to the IAGC sample trigger. Decimates the ADC data-valid strobe by a ratio latched at run start. Produces one registered sample strobe per gated channel. Optionally stops after a programmable burst of samples until re-armed. Sits between the IAGC controller (status input) and the per-channel sample capture/accumulation logic.

## Interface
- IAGC_STATUS_SIZE, 4, width of IAGC status word
- NUM_CHANNELS, 4, number of independent gated output strobes
- DECIM_WIDTH, 8, width of decimation ratio
- BURST_WIDTH, 10, width of burst length and sample counter
- i_clock  in  1  sole clock, all state on rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_iagc_status  in  IAGC_STATUS_SIZE  IAGC state; 4'b0000 RESET, 4'b0001 INIT
- i_decim  in  DECIM_WIDTH  decimation ratio N; 0 treated as 1
- i_adc_data_valid  in  1  one-cycle ADC sample strobe
- i_gate  in  NUM_CHANNELS  per-channel enable, sampled same cycle as tick
- i_burst_len  in  BURST_WIDTH  samples per burst; 0 = continuous
- i_arm  in  1  one-cycle pulse, restarts a finished burst
- o_valid  out  NUM_CHANNELS  registered per-channel sample strobe
- o_busy  out  1  high in RUN
- o_done  out  1  high in DONE
- o_sample_count  out  BURST_WIDTH  decimated ticks since run start

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE; all outputs 0, counters 0.
- hold = (status == RESET or INIT). hold in any state -> IDLE next edge; counters cleared; o_valid 0.
- IDLE -> RUN when not hold. On this transition latch ratio decim_q = max(i_decim, 1). Clear phase counter and o_sample_count.
- RUN: phase counter advances only on cycles with i_adc_data_valid. tick = i_adc_data_valid and phase == decim_q-1. On tick phase wraps to 0; otherwise phase+1.
- On tick: o_sample_count increments; o_valid[c] <= i_gate[c] for each c. On non-tick cycles o_valid <= 0.
- The counter increments on every tick whether or not any gate is set.
- Changes to i_decim during RUN are ignored until the next IDLE -> RUN.
- Continuous (i_burst_len == 0, or macro off): o_sample_count wraps 2^BURST_WIDTH-1 -> 0.
- Burst (macro on, i_burst_len_q != 0): i_burst_len is latched with decim_q. The tick that makes the count equal to the burst length moves the block to DONE. That tick's o_valid still issues.
- DONE: no ticks, o_valid 0, o_sample_count holds. i_arm -> RUN; phase and count cleared; ratio and burst length re-latched.
- i_arm in IDLE or RUN is ignored. hold has priority over i_arm.

## Timing
- o_valid latency: 1 cycle after the qualifying i_adc_data_valid edge. Strobe width is exactly 1 cycle.
- First strobe after entering RUN occurs on the N-th valid strobe. This includes a valid strobe in the same cycle RUN is entered: that strobe counts as phase 0.
- N=1: every valid strobe yields a strobe.
- o_busy and o_done are registered state decodes. Each is 1 cycle after the transition-causing edge.
- Asserting i_reset_n low clears everything immediately, regardless of clock.
- Hold asserted mid-run: phase and count are discarded, and a tick in that same cycle is suppressed.

## Configuration
- SAMPLE_TRIGGER_BURST_EN defined: DONE state, i_burst_len latching, and i_arm restart are compiled in.
- SAMPLE_TRIGGER_BURST_EN undefined: always continuous. DONE is unreachable and removed. o_done is tied 0. i_arm and i_burst_len are unused.

## Test plan
- Reset release, status=2, i_decim=4, valid every cycle, gate=4'b0101 -> o_valid=4'b0101 on cycles 4, 8, 12 after RUN entry; o_sample_count 1, 2, 3.
- i_decim=0, valid every 3rd cycle -> one strobe per valid (treated as N=1). Changing i_decim to 5 mid-run does not change the rate.
- Burst (macro on): N=2, burst_len=3, continuous valid -> 3 strobes, o_done=1, count=3, no further strobes. i_arm -> o_done 0, count restarts at 0, new burst of 3 strobes.
- Status forced to INIT while phase=2 of N=4, with valid in the same cycle -> no strobe, IDLE, count 0. Return to status=2 -> next strobe after 4 more valids.
- i_reset_n pulsed low between clock edges mid-run -> all outputs 0 immediately. Macro off: o_done stays 0 and count wraps 1023 -> 0 with BURST_WIDTH=10.

Source files
------------

// File: rtl/sample_trigger_mc.sv
// Decimates the ADC valid strobe into registered per-channel sample strobes; optional burst/DONE/re-arm under SAMPLE_TRIGGER_BURST_EN.
// Latency: o_valid one cycle after the qualifying valid strobe; no backpressure, status hold overrides everything.
module sample_trigger_mc #(
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int NUM_CHANNELS     = 4,
  parameter int DECIM_WIDTH      = 8,
  parameter int BURST_WIDTH      = 10
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
  input  logic [DECIM_WIDTH-1:0]      i_decim,
  input  logic                        i_adc_data_valid,
  input  logic [NUM_CHANNELS-1:0]     i_gate,
  input  logic [BURST_WIDTH-1:0]      i_burst_len,
  input  logic                        i_arm,
  output logic [NUM_CHANNELS-1:0]     o_valid,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [BURST_WIDTH-1:0]      o_sample_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
`ifdef SAMPLE_TRIGGER_BURST_EN
    , S_DONE = 2'd2
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [DECIM_WIDTH-1:0]  decim_q, decim_d;
  logic [DECIM_WIDTH-1:0]  phase_q, phase_d;
  logic [BURST_WIDTH-1:0]  count_q, count_d;
  logic [NUM_CHANNELS-1:0] valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    hold;
  logic [DECIM_WIDTH-1:0]  ratio_in;
  logic                    run_en;
  logic [DECIM_WIDTH-1:0]  eff_decim;
  logic [DECIM_WIDTH-1:0]  cur_phase;
  logic [BURST_WIDTH-1:0]  cur_count;

`ifdef SAMPLE_TRIGGER_BURST_EN
  logic [BURST_WIDTH-1:0]  burst_q, burst_d;
  logic [BURST_WIDTH-1:0]  eff_burst;
`else
  logic                    unused_burst;
  assign unused_burst = ^{i_arm, i_burst_len};
`endif

  assign hold     = (i_iagc_status == '0) || (i_iagc_status == IAGC_STATUS_SIZE'(1));
  assign ratio_in = (i_decim == '0) ? DECIM_WIDTH'(1) : i_decim;

  always_comb begin
    state_d   = state_q;
    decim_d   = decim_q;
    phase_d   = phase_q;
    count_d   = count_q;
    valid_d   = '0;
    run_en    = 1'b0;
    eff_decim = decim_q;
    cur_phase = phase_q;
    cur_count = count_q;
`ifdef SAMPLE_TRIGGER_BURST_EN
    burst_d   = burst_q;
    eff_burst = burst_q;
`endif

    if (hold) begin
      state_d = S_IDLE;
      phase_d = '0;
      count_d = '0;
    end else begin
      // A start (from IDLE or re-arm) runs the same cycle with fresh settings, so a
      // valid strobe arriving with the start counts as phase 0.
      case (state_q)
        S_IDLE: begin
          run_en    = 1'b1;
          state_d   = S_RUN;
          decim_d   = ratio_in;
          eff_decim = ratio_in;
          cur_phase = '0;
          cur_count = '0;
`ifdef SAMPLE_TRIGGER_BURST_EN
          burst_d   = i_burst_len;
          eff_burst = i_burst_len;
`endif
        end
        S_RUN: run_en = 1'b1;
`ifdef SAMPLE_TRIGGER_BURST_EN
        S_DONE: begin
          if (i_arm) begin
            run_en    = 1'b1;
            state_d   = S_RUN;
            decim_d   = ratio_in;
            eff_decim = ratio_in;
            cur_phase = '0;
            cur_count = '0;
            burst_d   = i_burst_len;
            eff_burst = i_burst_len;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase

      if (run_en) begin
        phase_d = cur_phase;
        count_d = cur_count;
        if (i_adc_data_valid) begin
          if (cur_phase == eff_decim - DECIM_WIDTH'(1)) begin
            phase_d = '0;
            count_d = cur_count + BURST_WIDTH'(1);
            valid_d = i_gate;
`ifdef SAMPLE_TRIGGER_BURST_EN
            if ((eff_burst != '0) && (count_d == eff_burst)) state_d = S_DONE;
`endif
          end else begin
            phase_d = cur_phase + DECIM_WIDTH'(1);
          end
        end
      end
    end

    busy_d = (state_d == S_RUN);
`ifdef SAMPLE_TRIGGER_BURST_EN
    done_d = (state_d == S_DONE);
`else
    done_d = 1'b0;
`endif
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      decim_q <= '0;
      phase_q <= '0;
      count_q <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SAMPLE_TRIGGER_BURST_EN
      burst_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      decim_q <= decim_d;
      phase_q <= phase_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SAMPLE_TRIGGER_BURST_EN
      burst_q <= burst_d;
`endif
    end
  end

  assign o_valid        = valid_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_sample_count = count_q;

endmodule

// File: tb/tb_sample_trigger_mc.sv
// Bench for sample_trigger_mc: hand-derived vector table, then model-fed scoreboard sequences for multi-cycle corners.
module tb_sample_trigger_mc;
  localparam int SW = 4;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int BW = 10;
`ifdef SAMPLE_TRIGGER_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic          i_clock = 1'b0;
  logic          i_reset_n;
  logic [SW-1:0] i_iagc_status;
  logic [DW-1:0] i_decim;
  logic          i_adc_data_valid;
  logic [NC-1:0] i_gate;
  logic [BW-1:0] i_burst_len;
  logic          i_arm;
  logic [NC-1:0] o_valid;
  logic          o_busy;
  logic          o_done;
  logic [BW-1:0] o_sample_count;

  sample_trigger_mc #(
    .IAGC_STATUS_SIZE(SW), .NUM_CHANNELS(NC), .DECIM_WIDTH(DW), .BURST_WIDTH(BW)
  ) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_iagc_status(i_iagc_status),
    .i_decim(i_decim), .i_adc_data_valid(i_adc_data_valid), .i_gate(i_gate),
    .i_burst_len(i_burst_len), .i_arm(i_arm), .o_valid(o_valid), .o_busy(o_busy),
    .o_done(o_done), .o_sample_count(o_sample_count)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [NC-1:0] valid;
    logic          busy;
    logic          done;
    logic [BW-1:0] count;
  } exp_t;

  typedef struct {
    logic [SW-1:0] status;
    logic [DW-1:0] decim;
    logic          adc_vld;
    logic [NC-1:0] gate;
    logic [NC-1:0] exp_valid;
    logic          exp_busy;
    logic [BW-1:0] exp_count;
  } vec_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: 0 idle, 1 run, 2 done
  int            m_state, m_decim, m_phase, m_count, m_burst;
  logic [NC-1:0] m_valid;

  task automatic model_reset();
    m_state = 0; m_decim = 1; m_phase = 0; m_count = 0; m_burst = 0; m_valid = '0;
  endtask

  task automatic model_step(input int st, input int dc, input bit v, input logic [NC-1:0] g,
                            input int bl, input bit arm);
    bit restart;
    m_valid = '0;
    if (st == 0 || st == 1) begin
      m_state = 0; m_phase = 0; m_count = 0;
    end else begin
      restart = (m_state == 0) || (BURST_EN && m_state == 2 && arm);
      if (restart) begin
        m_decim = (dc == 0) ? 1 : dc;
        m_burst = BURST_EN ? bl : 0;
        m_phase = 0; m_count = 0; m_state = 1;
      end
      if (m_state == 1 && v) begin
        if (m_phase == m_decim - 1) begin
          m_phase = 0;
          m_count = (m_count + 1) % (1 << BW);
          m_valid = g;
          if (m_burst != 0 && m_count == m_burst) m_state = 2;
        end else begin
          m_phase = m_phase + 1;
        end
      end
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.valid = m_valid;
    e.busy  = (m_state == 1);
    e.done  = (m_state == 2);
    e.count = BW'(m_count);
    return e;
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    if (o_valid !== e.valid || o_busy !== e.busy || o_done !== e.done || o_sample_count !== e.count) begin
      n_err++;
      $display("FAIL %s: got valid=%b busy=%b done=%b count=%0d, want valid=%b busy=%b done=%b count=%0d",
               tag, o_valid, o_busy, o_done, o_sample_count, e.valid, e.busy, e.done, e.count);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Called at a falling edge: drive, predict, advance one cycle, compare.
  task automatic step(input int st, input int dc, input bit v, input logic [NC-1:0] g,
                      input int bl, input bit arm, input string tag);
    i_iagc_status = SW'(st); i_decim = DW'(dc); i_adc_data_valid = v;
    i_gate = g; i_burst_len = BW'(bl); i_arm = arm;
    model_step(st, dc, v, g, bl, arm);
    sb_q.push_back(model_exp());
    @(negedge i_clock);
    check_out(tag);
  endtask

  vec_t tbl[15];

  initial begin
    exp_t e;
    // status, decim, valid, gate, exp o_valid, exp busy, exp count
    tbl[0]  = '{4'd0, 8'd4, 1'b1, 4'b0101, 4'b0000, 1'b0, 10'd0};
    tbl[1]  = '{4'd2, 8'd4, 1'b1, 4'b0101, 4'b0000, 1'b1, 10'd0};
    tbl[2]  = '{4'd2, 8'd4, 1'b1, 4'b0101, 4'b0000, 1'b1, 10'd0};
    tbl[3]  = '{4'd2, 8'd4, 1'b1, 4'b0101, 4'b0000, 1'b1, 10'd0};
    tbl[4]  = '{4'd2, 8'd4, 1'b1, 4'b0101, 4'b0101, 1'b1, 10'd1};
    tbl[5]  = '{4'd2, 8'd4, 1'b1, 4'b0101, 4'b0000, 1'b1, 10'd1};
    tbl[6]  = '{4'd2, 8'd4, 1'b1, 4'b0101, 4'b0000, 1'b1, 10'd1};
    tbl[7]  = '{4'd2, 8'd4, 1'b1, 4'b0101, 4'b0000, 1'b1, 10'd1};
    tbl[8]  = '{4'd2, 8'd4, 1'b1, 4'b0101, 4'b0101, 1'b1, 10'd2};
    tbl[9]  = '{4'd2, 8'd4, 1'b0, 4'b1010, 4'b0000, 1'b1, 10'd2};
    tbl[10] = '{4'd2, 8'd4, 1'b1, 4'b1010, 4'b0000, 1'b1, 10'd2};
    tbl[11] = '{4'd2, 8'd1, 1'b1, 4'b1010, 4'b0000, 1'b1, 10'd2};
    tbl[12] = '{4'd2, 8'd1, 1'b1, 4'b1010, 4'b0000, 1'b1, 10'd2};
    tbl[13] = '{4'd3, 8'd1, 1'b1, 4'b1010, 4'b1010, 1'b1, 10'd3};
    tbl[14] = '{4'd1, 8'd4, 1'b1, 4'b1111, 4'b0000, 1'b0, 10'd0};

    i_reset_n = 1'b0; i_iagc_status = '0; i_decim = '0; i_adc_data_valid = 1'b0;
    i_gate = '0; i_burst_len = '0; i_arm = 1'b0;
    model_reset();
    @(negedge i_clock);
    sb_q.push_back(model_exp());
    check_out("reset");
    i_reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      i_iagc_status = tbl[i].status; i_decim = tbl[i].decim;
      i_adc_data_valid = tbl[i].adc_vld; i_gate = tbl[i].gate;
      i_burst_len = '0; i_arm = 1'b0;
      model_step(tbl[i].status, tbl[i].decim, tbl[i].adc_vld, tbl[i].gate, 0, 1'b0);
      e.valid = tbl[i].exp_valid; e.busy = tbl[i].exp_busy; e.done = 1'b0; e.count = tbl[i].exp_count;
      sb_q.push_back(e);
      @(negedge i_clock);
      check_out($sformatf("tbl%0d", i));
    end

    // Ratio 0 acts as 1; a new ratio mid-run must be ignored.
    for (int i = 0; i < 24; i++)
      step(2, (i < 12) ? 0 : 5, (i % 3) == 0, 4'b0011, 0, 1'b0, $sformatf("decim0_%0d", i));
    check_val("decim0_count", o_sample_count, 8);

    // Hold while at phase 2 of N=4 with a valid in the same cycle.
    step(0, 4, 1'b0, 4'b1001, 0, 1'b0, "hold_pre");
    step(2, 4, 1'b1, 4'b1001, 0, 1'b0, "hold_run0");
    step(2, 4, 1'b1, 4'b1001, 0, 1'b0, "hold_run1");
    step(1, 4, 1'b1, 4'b1001, 0, 1'b0, "hold_init");
    check_val("hold_valid", o_valid, 0);
    check_val("hold_count", o_sample_count, 0);
    for (int i = 0; i < 4; i++) step(2, 4, 1'b1, 4'b1001, 0, 1'b0, $sformatf("hold_post%0d", i));
    check_val("hold_restrobe", o_valid, 4'b1001);

    // Asynchronous reset between clock edges.
    step(2, 1, 1'b1, 4'b1111, 0, 1'b0, "ar_run0");
    step(2, 1, 1'b1, 4'b1111, 0, 1'b0, "ar_run1");
    #2 i_reset_n = 1'b0;
    #1;
    check_val("arst_valid", o_valid, 0);
    check_val("arst_busy", o_busy, 0);
    check_val("arst_done", o_done, 0);
    check_val("arst_count", o_sample_count, 0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    model_reset();

    // Continuous wrap of the sample counter.
    step(0, 1, 1'b0, 4'b0000, 0, 1'b0, "wrap_pre");
    for (int i = 0; i < 1025; i++) begin
      step(2, 1, 1'b1, 4'b0110, 0, 1'b0, $sformatf("wrap%0d", i));
      if (i == 1022) check_val("wrap_top", o_sample_count, 1023);
      if (i == 1023) check_val("wrap_zero", o_sample_count, 0);
    end
    check_val("wrap_done", o_done, 0);

`ifdef SAMPLE_TRIGGER_BURST_EN
    step(0, 2, 1'b0, 4'b0000, 3, 1'b0, "burst_pre");
    for (int i = 0; i < 10; i++) step(2, 2, 1'b1, 4'b1100, 3, 1'b0, $sformatf("burst_a%0d", i));
    check_val("burst_done", o_done, 1);
    check_val("burst_count", o_sample_count, 3);
    step(2, 2, 1'b1, 4'b1100, 3, 1'b1, "burst_arm");
    check_val("arm_done", o_done, 0);
    check_val("arm_count", o_sample_count, 0);
    for (int i = 0; i < 10; i++) step(2, 2, 1'b1, 4'b1100, 3, 1'b0, $sformatf("burst_b%0d", i));
    check_val("burst2_count", o_sample_count, 3);
`endif

    // Randomised mix across all inputs, checked by the model.
    for (int i = 0; i < 300; i++) begin
      int st;
      st = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 3));
      step(st, $urandom_range(0, 3), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
           $urandom_range(0, 4), $urandom_range(0, 7) == 0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
